// File: rtl/onehot_arb2.sv
// onehot_arb2: two-input round-robin arbiter feeding a one-entry output register.
// Latency: a transfer in cycle N shows up as out_valid/out_data/out_src in cycle N+1; drain+load has no bubble.
// Backpressure: while FULL with out_ready=0, sel=00, both readys are 0 and the output register holds.
//
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   reqN_valid/data/ready      - producer N handshake (N = 0,1); reqN_ready = sel[N]
//   sel                        - one-hot grant {g1,g0} or 00, drives onehot_mux2.s
//   out_valid/data/src/ready   - registered result toward the consumer; out_src = winning index
//
// Build option: define ONEHOT_ARB2_FIXED_PRIO_EN for fixed priority (req0 always wins a
// contest); the priority register is then not built. Default is round-robin.
module onehot_arb2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic [1:0]       sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready
);

   logic             load_en;
   logic             prefer1;
   logic [WIDTH-1:0] mux_data;

`ifdef ONEHOT_ARB2_FIXED_PRIO_EN
   assign prefer1 = 1'b0;
`else
   // prio=1 means req1 wins the next contest; it points away from the last winner.
   logic prio;
   assign prefer1 = prio;

   always_ff @(posedge clk) begin
      if (rst) begin
         prio <= 1'b0;
      end else if (sel != 2'b00) begin
         prio <= ~sel[1];
      end
   end
`endif

   // Reset is folded in here so no grant (and no ready) is ever raised while rst=1.
   assign load_en = (!out_valid || out_ready) && !rst;

   // The if/else-if structure guarantees sel is never 2'b11.
   always_comb begin
      sel = 2'b00;
      if (load_en) begin
         if (req0_valid && (!req1_valid || !prefer1)) begin
            sel = 2'b01;
         end else if (req1_valid) begin
            sel = 2'b10;
         end
      end
   end

   assign req0_ready = sel[0];
   assign req1_ready = sel[1];

   // Same AND-OR selection as the downstream onehot_mux2.
   assign mux_data = ({WIDTH{sel[0]}} & req0_data) | ({WIDTH{sel[1]}} & req1_data);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
      end else if (sel != 2'b00) begin
         out_valid <= 1'b1;
         out_data  <= mux_data;
         out_src   <= sel[1];
      end else if (out_ready) begin
         // Drain without a replacement: data and source hold, only valid drops.
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_onehot_arb2.sv
// tb_onehot_arb2: directed vector table plus randomized traffic against a reference model.
// Latency: n/a (testbench).
// Backpressure: random out_ready stalls; producers hold valid/data until their transfer.
module tb_onehot_arb2;

`ifdef ONEHOT_ARB2_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0;
   logic [31:0] req0_data = '0;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [31:0] req1_data = '0;
   logic        req1_ready;
   logic [1:0]  sel;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_src;
   logic        out_ready = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   onehot_arb2 #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .sel        (sel),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_src    (out_src),
      .out_ready  (out_ready)
   );

   // Reference model: the output slot as a flag + contents, and the index of the last winner.
   bit        m_full = 1'b0;
   bit [31:0] m_data = '0;
   bit        m_src  = 1'b0;
   int        m_last = 1;   // after reset req0 is favoured, i.e. "req1 won last"

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: apply inputs, check the combinational grant, clock, check the register.
   task automatic cycle(input logic r, input logic v0, input logic [31:0] d0,
                        input logic v1, input logic [31:0] d1, input logic ordy,
                        output logic [1:0] o_sel, output logic o_ov,
                        output logic [31:0] o_od, output logic o_os);
      int winner;
      logic [1:0] exp_sel;
      @(negedge clk);
      rst = r; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
      out_ready = ordy;
      #1;
      winner = -1;
      if (!r && !(m_full && !ordy)) begin
         if (v0 && v1)  winner = FIXED ? 0 : 1 - m_last;
         else if (v0)   winner = 0;
         else if (v1)   winner = 1;
      end
      exp_sel = (winner < 0) ? 2'b00 : ((winner == 0) ? 2'b01 : 2'b10);
      chk("sel", {30'd0, sel}, {30'd0, exp_sel});
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, exp_sel[0]});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, exp_sel[1]});
      chk("sel_not_11", {31'd0, sel == 2'b11}, 32'd0);
      o_sel = sel;
      @(posedge clk);
      if (r) begin
         m_full = 0; m_data = '0; m_src = 0; m_last = 1;
      end else if (winner >= 0) begin
         m_full = 1; m_data = (winner == 0) ? d0 : d1; m_src = (winner == 1); m_last = winner;
      end else if (m_full && ordy) begin
         m_full = 0;
      end
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      chk("out_data", out_data, m_data);
      chk("out_src", {31'd0, out_src}, {31'd0, m_src});
      o_ov = out_valid; o_od = out_data; o_os = out_src;
   endtask

   typedef struct {
      logic        r;
      logic        v0;
      logic [31:0] d0;
      logic        v1;
      logic [31:0] d1;
      logic        ordy;
      logic [1:0]  e_sel;
      logic        e_ov;
      logic [31:0] e_od;
      logic        e_os;
   } vec_t;

   vec_t vecs[16];

   initial begin
      logic [1:0]  s;
      logic        ov, os;
      logic [31:0] od;
      logic        pv0, pv1, rr, ordy;
      logic [31:0] pd0, pd1;

      // Directed sequence (row order matters: each row is one clock).
      vecs[0]  = '{1, 0, 32'h0, 0, 32'h0, 1, 2'b00, 0, 32'h0, 0};                       // reset
      vecs[1]  = '{0, 1, 32'h000000FF, 0, 32'h0, 1, 2'b01, 1, 32'h000000FF, 0};         // req0 only
      vecs[2]  = '{0, 0, 32'h0, 1, 32'h0000FF00, 1, 2'b10, 1, 32'h0000FF00, 1};         // req1 only
      vecs[3]  = '{0, 1, 32'h11111111, 1, 32'h22222222, 1, 2'b01, 1, 32'h11111111, 0};  // contest
      vecs[4]  = '{0, 1, 32'h11111111, 1, 32'h22222222, 1,
                   FIXED ? 2'b01 : 2'b10, 1, FIXED ? 32'h11111111 : 32'h22222222, !FIXED};
      vecs[5]  = '{0, 1, 32'h11111111, 1, 32'h22222222, 1, 2'b01, 1, 32'h11111111, 0};
      vecs[6]  = '{0, 1, 32'h11111111, 1, 32'h22222222, 1,
                   FIXED ? 2'b01 : 2'b10, 1, FIXED ? 32'h11111111 : 32'h22222222, !FIXED};
      vecs[7]  = '{0, 1, 32'hA5A5A5A5, 0, 32'h0, 1, 2'b01, 1, 32'hA5A5A5A5, 0};         // fill
      vecs[8]  = '{0, 1, 32'h33333333, 1, 32'h44444444, 0, 2'b00, 1, 32'hA5A5A5A5, 0};  // stall x3
      vecs[9]  = '{0, 1, 32'h33333333, 1, 32'h44444444, 0, 2'b00, 1, 32'hA5A5A5A5, 0};
      vecs[10] = '{0, 1, 32'h33333333, 1, 32'h44444444, 0, 2'b00, 1, 32'hA5A5A5A5, 0};
      vecs[11] = '{0, 1, 32'h33333333, 1, 32'h44444444, 1,                               // drain+load
                   FIXED ? 2'b01 : 2'b10, 1, FIXED ? 32'h33333333 : 32'h44444444, !FIXED};
      vecs[12] = '{0, 0, 32'h0, 0, 32'h0, 1, 2'b00, 0,                                   // drain only
                   FIXED ? 32'h33333333 : 32'h44444444, !FIXED};
      vecs[13] = '{0, 1, 32'h55555555, 1, 32'h66666666, 1, 2'b01, 1, 32'h55555555, 0};  // prio held
      vecs[14] = '{1, 1, 32'h77777777, 1, 32'h88888888, 1, 2'b00, 0, 32'h0, 0};         // rst wins
      vecs[15] = '{0, 1, 32'h77777777, 1, 32'h88888888, 1, 2'b01, 1, 32'h77777777, 0};  // prio reset

      for (int i = 0; i < 16; i++) begin
         cycle(vecs[i].r, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy,
               s, ov, od, os);
         chk($sformatf("vec%0d_sel", i), {30'd0, s}, {30'd0, vecs[i].e_sel});
         chk($sformatf("vec%0d_out_valid", i), {31'd0, ov}, {31'd0, vecs[i].e_ov});
         chk($sformatf("vec%0d_out_data", i), od, vecs[i].e_od);
         chk($sformatf("vec%0d_out_src", i), {31'd0, os}, {31'd0, vecs[i].e_os});
      end

      // Throughput: out_ready held high with both producers always valid -> a result every cycle.
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, 32'h1000 + i, 1'b1, 32'h2000 + i, 1'b1, s, ov, od, os);
         chk("stream_valid", {31'd0, ov}, 32'd1);
      end

      // Randomized traffic; producers keep valid/data stable until granted.
      pv0 = 0; pv1 = 0; pd0 = '0; pd1 = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!pv0 && $urandom_range(0, 2) != 0) begin pv0 = 1; pd0 = $urandom; end
         if (!pv1 && $urandom_range(0, 2) != 0) begin pv1 = 1; pd1 = $urandom; end
         rr   = ($urandom_range(0, 63) == 0);
         ordy = ($urandom_range(0, 3) != 0);
         cycle(rr, pv0, pd0, pv1, pd1, ordy, s, ov, od, os);
         if (s[0]) pv0 = 0;
         if (s[1]) pv1 = 0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
